// File: rtl/sbentsrc_reader.sv
// Consumer of the sbentsrc raw-bit stream: online health tests, warm-up discard, LSB-first packing.
// SBENTSRC_READER_DROPCNT_EN adds o_drop_cnt, a saturating count of words lost to backpressure.
module sbentsrc_reader #(
  parameter int RNG_WIDTH  = 4,
  parameter int OUT_WIDTH  = 32,
  parameter int WARMUP     = 16,
  parameter int RCT_CUTOFF = 8,
  parameter int APT_WINDOW = 64,
  parameter int APT_CUTOFF = 40
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_en,
  input  logic [RNG_WIDTH-1:0] i_raw,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_alarm,
  output logic                 o_alarm_rct,
  output logic                 o_alarm_apt,
`ifdef SBENTSRC_READER_DROPCNT_EN
  output logic [7:0]           o_drop_cnt,
`endif
  output logic                 o_busy
);

  localparam int K   = OUT_WIDTH / RNG_WIDTH;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int WW  = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int RCW = $clog2(RCT_CUTOFF + 1);
  localparam int ACW = $clog2(APT_CUTOFF + 1);
  localparam int AIW = $clog2(APT_WINDOW);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_ALARM} state_t;
  state_t state, state_nxt;

  logic                 sample, rct_fail, apt_fail, fail;
  logic                 warm_last, word_done, out_free;
  logic [RCW-1:0]       rct_cnt, rct_nxt;
  logic [RNG_WIDTH-1:0] rct_last, apt_ref;
  logic [ACW-1:0]       apt_cnt, apt_nxt;
  logic [AIW-1:0]       win_idx;
  logic [WW-1:0]        warm_cnt;
  logic [KW-1:0]        part_cnt;
  logic [OUT_WIDTH-1:0] part, word_nxt;

  assign sample    = i_en && (state == S_WARMUP || state == S_RUN);
  assign warm_last = (32'(warm_cnt) == WARMUP - 1);
  assign word_done = (32'(part_cnt) == K - 1);
  assign out_free  = !o_valid || i_ready;

  // rct_cnt==0 only before the first sample after reset
  always_comb begin
    rct_nxt = (rct_cnt == '0 || i_raw != rct_last) ? RCW'(1) : rct_cnt + RCW'(1);
    if (win_idx == '0)        apt_nxt = ACW'(1);
    else if (i_raw == apt_ref) apt_nxt = apt_cnt + ACW'(1);
    else                       apt_nxt = apt_cnt;
    rct_fail = sample && (rct_nxt == RCW'(RCT_CUTOFF));
    apt_fail = sample && (apt_nxt == ACW'(APT_CUTOFF));
    fail     = rct_fail || apt_fail;
    word_nxt = part;
    word_nxt[int'(part_cnt)*RNG_WIDTH +: RNG_WIDTH] = i_raw;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (i_en) state_nxt = (WARMUP == 0) ? S_RUN : S_WARMUP;
      S_WARMUP: if (fail) state_nxt = S_ALARM;
                else if (sample && warm_last) state_nxt = S_RUN;
      S_RUN:    if (fail) state_nxt = S_ALARM;
      default:  state_nxt = state;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rct_cnt     <= '0;
      rct_last    <= '0;
      apt_cnt     <= '0;
      apt_ref     <= '0;
      win_idx     <= '0;
      warm_cnt    <= '0;
      part_cnt    <= '0;
      part        <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_alarm_rct <= 1'b0;
      o_alarm_apt <= 1'b0;
`ifdef SBENTSRC_READER_DROPCNT_EN
      o_drop_cnt  <= '0;
`endif
    end else begin
      if (sample) begin
        rct_last <= i_raw;
        rct_cnt  <= rct_nxt;
        apt_cnt  <= apt_nxt;
        if (win_idx == '0) apt_ref <= i_raw;
        win_idx  <= (32'(win_idx) == APT_WINDOW - 1) ? '0 : win_idx + AIW'(1);
        if (state == S_WARMUP) warm_cnt <= warm_cnt + WW'(1);
      end
      if (o_valid && i_ready) o_valid <= 1'b0;
      // a failing sample kills the partial word and any unaccepted output
      if (fail) begin
        o_alarm_rct <= o_alarm_rct | rct_fail;
        o_alarm_apt <= o_alarm_apt | apt_fail;
        o_valid     <= 1'b0;
        part        <= '0;
        part_cnt    <= '0;
      end else if (sample && state == S_RUN) begin
        if (word_done) begin
          part     <= '0;
          part_cnt <= '0;
          if (out_free) begin
            o_data  <= word_nxt;
            o_valid <= 1'b1;
          end
`ifdef SBENTSRC_READER_DROPCNT_EN
          else if (o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
`endif
        end else begin
          part     <= word_nxt;
          part_cnt <= part_cnt + KW'(1);
        end
      end
    end
  end

  assign o_alarm = o_alarm_rct | o_alarm_apt;
  assign o_busy  = (state == S_WARMUP) || (state == S_RUN);

endmodule

// File: tb/tb_sbentsrc_reader.sv
// Scoreboard bench for sbentsrc_reader: history-based reference model, directed scenarios, random soak.
module tb_sbentsrc_reader;
  localparam int RW = 4, OW = 16, WU = 2, RC = 4, AW = 16, AC = 10;
  localparam int K = OW / RW;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1, i_en = 1'b0, i_ready = 1'b0;
  logic [RW-1:0] i_raw = '0;
  logic [OW-1:0] o_data;
  logic          o_valid, o_alarm, o_alarm_rct, o_alarm_apt, o_busy;
`ifdef SBENTSRC_READER_DROPCNT_EN
  logic [7:0]    o_drop_cnt;
`endif

  sbentsrc_reader #(.RNG_WIDTH(RW), .OUT_WIDTH(OW), .WARMUP(WU), .RCT_CUTOFF(RC),
                    .APT_WINDOW(AW), .APT_CUTOFF(AC)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_en(i_en), .i_raw(i_raw),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_alarm(o_alarm), .o_alarm_rct(o_alarm_rct), .o_alarm_apt(o_alarm_apt),
`ifdef SBENTSRC_READER_DROPCNT_EN
    .o_drop_cnt(o_drop_cnt),
`endif
    .o_busy(o_busy));

  always #5 clk = ~clk;

  int checks = 0, passes = 0;

  // reference model: every sample since reset is kept; tests are recomputed from history
  logic [OW-1:0] sb[$];
  logic [RW-1:0] hist[$], word[$];
  bit m_act, m_pend, m_rct, m_apt;
  int m_drops;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_step();
    int n, run, ws, ac;
    logic [OW-1:0] v;
    if (i_reset) begin
      hist.delete(); word.delete(); sb.delete();
      m_act = 0; m_pend = 0; m_rct = 0; m_apt = 0; m_drops = 0;
      return;
    end
    if (m_pend && i_ready) m_pend = 0;
    if (!m_act) begin m_act = i_en; return; end
    if (m_rct || m_apt || !i_en) return;
    hist.push_back(i_raw);
    n = hist.size() - 1;
    run = 0;
    for (int j = n; j >= 0 && hist[j] == i_raw; j--) run++;
    ws = (n / AW) * AW;
    ac = 0;
    for (int j = ws; j <= n; j++) if (hist[j] == hist[ws]) ac++;
    if (run >= RC || ac >= AC) begin
      m_rct = m_rct | (run >= RC);
      m_apt = m_apt | (ac >= AC);
      word.delete();
      if (m_pend) begin void'(sb.pop_back()); m_pend = 0; end
      return;
    end
    if (n >= WU) begin
      word.push_back(i_raw);
      if (word.size() == K) begin
        v = '0;
        for (int j = 0; j < K; j++) v[j*RW +: RW] = word[j];
        if (!m_pend) begin sb.push_back(v); m_pend = 1; end
        else m_drops++;
        word.delete();
      end
    end
  endtask

  // monitor: compares every cycle against the model, pops on handshake
  always @(negedge clk) begin
    chk("valid", {31'b0, o_valid}, {31'b0, m_pend});
    chk("busy", {31'b0, o_busy}, {31'b0, m_act && !(m_rct || m_apt)});
    chk("alarm_rct", {31'b0, o_alarm_rct}, {31'b0, m_rct});
    chk("alarm_apt", {31'b0, o_alarm_apt}, {31'b0, m_apt});
    chk("alarm", {31'b0, o_alarm}, {31'b0, m_rct || m_apt});
`ifdef SBENTSRC_READER_DROPCNT_EN
    chk("drop_cnt", {24'b0, o_drop_cnt}, (m_drops > 255) ? 32'd255 : 32'(m_drops));
`endif
    if (o_valid) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL data: got %0h with o_valid but expected no word at %0t", o_data, $time);
      end else begin
        chk("data", {16'b0, o_data}, {16'b0, sb[0]});
        if (i_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic cyc(input logic en, input logic [RW-1:0] raw, input logic rdy, input logic rst);
    i_en = en; i_raw = raw; i_ready = rdy; i_reset = rst;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic start();
    cyc(1'b0, 4'h0, 1'b1, 1'b1);
    cyc(1'b1, 4'h0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [RW-1:0] pat;
    int alpha;
    // 1: warm-up discard and LSB-first packing
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    chk("reset_valid", {31'b0, o_valid}, 32'd0);
    chk("reset_busy", {31'b0, o_busy}, 32'd0);
    cyc(1'b1, 4'h0, 1'b1, 1'b0);
    for (int s = 1; s <= 6; s++) cyc(1'b1, RW'(s), 1'b1, 1'b0);
    chk("t1_valid", {31'b0, o_valid}, 32'd1);
    chk("t1_data", {16'b0, o_data}, 32'h6543);
    cyc(1'b1, 4'h7, 1'b1, 1'b0);
    chk("t1_valid_drop", {31'b0, o_valid}, 32'd0);
    cyc(1'b1, 4'h8, 1'b1, 1'b0);
    // 2: repetition count failure
    cyc(1'b1, 4'h9, 1'b1, 1'b0);
    for (int s = 0; s < 4; s++) cyc(1'b1, 4'hA, 1'b1, 1'b0);
    chk("t2_rct", {31'b0, o_alarm_rct}, 32'd1);
    chk("t2_apt", {31'b0, o_alarm_apt}, 32'd0);
    chk("t2_valid", {31'b0, o_valid}, 32'd0);
    for (int s = 0; s < 3; s++) cyc(1'b1, RW'(s), 1'b1, 1'b0);
    chk("t2_sticky", {31'b0, o_alarm}, 32'd1);
    // 3: adaptive proportion failure on the 13th sample
    start();
    for (int s = 0; s < 13; s++) begin
      pat = (s % 4 == 3) ? 4'h1 : 4'h5;
      cyc(1'b1, pat, 1'b1, 1'b0);
      if (s == 11) chk("t3_apt_early", {31'b0, o_alarm_apt}, 32'd0);
    end
    chk("t3_apt", {31'b0, o_alarm_apt}, 32'd1);
    chk("t3_rct", {31'b0, o_alarm_rct}, 32'd0);
    // 4: backpressure holds first word, drops second
    start();
    cyc(1'b1, 4'hE, 1'b0, 1'b0);
    cyc(1'b1, 4'hF, 1'b0, 1'b0);
    for (int s = 1; s <= 8; s++) cyc(1'b1, RW'(s), 1'b0, 1'b0);
    chk("t4_hold", {16'b0, o_data}, 32'h4321);
`ifdef SBENTSRC_READER_DROPCNT_EN
    chk("t4_drop", {24'b0, o_drop_cnt}, 32'd1);
`endif
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("t4_accept", {31'b0, o_valid}, 32'd0);
    // 5: enable gap mid-word
    start();
    cyc(1'b1, 4'hE, 1'b1, 1'b0);
    cyc(1'b1, 4'hF, 1'b1, 1'b0);
    cyc(1'b1, 4'h1, 1'b1, 1'b0);
    cyc(1'b1, 4'h2, 1'b1, 1'b0);
    for (int s = 0; s < 5; s++) cyc(1'b0, RW'($urandom_range(0, 15)), 1'b1, 1'b0);
    cyc(1'b1, 4'h3, 1'b1, 1'b0);
    cyc(1'b1, 4'h4, 1'b1, 1'b0);
    chk("t5_data", {16'b0, o_data}, 32'h4321);
    // 6: reset mid-word then re-warm-up
    cyc(1'b1, 4'h6, 1'b1, 1'b0);
    cyc(1'b1, 4'h7, 1'b1, 1'b0);
    cyc(1'b1, 4'h8, 1'b1, 1'b1);
    chk("t6_busy", {31'b0, o_busy}, 32'd0);
    chk("t6_valid", {31'b0, o_valid}, 32'd0);
    cyc(1'b1, 4'h0, 1'b1, 1'b0);
    for (int s = 1; s <= 6; s++) cyc(1'b1, RW'(s + 8), 1'b1, 1'b0);
    chk("t6_data", {16'b0, o_data}, 32'hEDCB);
    // random soak: full alphabet and small alphabet segments
    for (int seg = 0; seg < 10; seg++) begin
      start();
      alpha = (seg % 2 == 0) ? 15 : 2;
      for (int c = 0; c < 200; c++)
        cyc(($urandom % 5) != 0, RW'($urandom_range(0, alpha)), ($urandom % 3) != 0, 1'b0);
    end
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
